// File: rtl/cam_writebram.sv
// Camera capture front end for the QVGA RGB565 frame buffer.
// Registers the sensor bus and pairs bytes into 16-bit pixels. Pixels are
// written linearly from address 0. Settling frames after enable are discarded,
// writes past the end of the buffer are blocked, and each captured frame end
// is flagged with a one-cycle pulse.
module cam_writebram #(
    parameter int FRAME_WORDS = 76800,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [16:0] frame_addr,
    output logic [15:0] frame_pixel,
    output logic        frame_we,
    output logic        frame_done,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,    // enabled, waiting for the first frame start
        S_SKIP,    // discarding settling frames
        S_WAIT,    // settling done, waiting for the next frame start
        S_ACTIVE   // capturing pixels
    } state_t;

    localparam int              SKW       = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [SKW-1:0]  SKIP_LAST = SKW'(SKIP_FRAMES);
    localparam logic [16:0]     FULL_PTR  = 17'(FRAME_WORDS);

    // Registered sensor bus
    logic           r_vsync;
    logic           r_vsync_d;
    logic           r_href;
    logic [7:0]     r_data;

    // Control and datapath state
    state_t         r_state;
    state_t         w_state_nxt;
    logic [SKW-1:0] r_skip_cnt;
    logic           r_phase;
    logic [7:0]     r_high;
    logic [16:0]    r_wr_ptr;
    logic [16:0]    r_frame_addr;
    logic [15:0]    r_frame_pixel;
    logic           r_frame_we;
    logic           r_frame_done;
    logic           r_overflow;

    // Decoded events and FSM outputs
    logic           w_vsync_rise;
    logic           w_vsync_fall;
    logic           w_skip_last;
    logic           w_ptr_clear;
    logic           w_skip_clear;
    logic           w_skip_inc;
    logic           w_capture;
    logic           w_issue;
    logic           w_in_range;
    logic           w_done;

    assign w_vsync_rise = r_vsync & ~r_vsync_d;
    assign w_vsync_fall = ~r_vsync & r_vsync_d;
    assign w_skip_last  = (r_skip_cnt + SKW'(1)) == SKIP_LAST;
    assign w_in_range   = r_wr_ptr < FULL_PTR;

    // Register the sensor pins once; everything downstream uses these copies
    // NOTE: non-blocking assignments in clocked blocks keep every register
    // sampling the pre-edge value, so the pipeline order cannot race.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_vsync   <= cam_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= cam_href;
            r_data    <= cam_data;
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; enable changes only act on frame boundaries
    // NOTE: the default assignment at the top of a combinational block gives
    // every path a value, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (capture_en) w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (!capture_en)       w_state_nxt = S_IDLE;
                else if (w_vsync_fall) w_state_nxt = (SKIP_FRAMES > 0) ? S_SKIP : S_ACTIVE;
            end
            S_SKIP: begin
                if (w_vsync_rise) begin
                    if (!capture_en)      w_state_nxt = S_IDLE;
                    else if (w_skip_last) w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!capture_en)       w_state_nxt = S_IDLE;
                else if (w_vsync_fall) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_vsync_rise && !capture_en) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: pointer restart, skip counting and byte-capture qualifiers
    always_comb begin
        w_ptr_clear  = 1'b0;
        w_skip_clear = 1'b0;
        w_skip_inc   = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            S_SYNC: begin
                w_skip_clear = w_vsync_fall;
                w_ptr_clear  = w_vsync_fall && (SKIP_FRAMES == 0);
            end
            S_SKIP: begin
                w_skip_inc = w_vsync_rise;
            end
            S_WAIT: begin
                w_ptr_clear = w_vsync_fall;
            end
            S_ACTIVE: begin
                w_ptr_clear = w_vsync_fall;
                // A frame end discards a pending high byte
                w_capture   = r_href && !w_vsync_rise;
                w_done      = w_vsync_rise;
            end
            default: ;
        endcase
        w_issue = w_capture && r_phase;
    end

    // Count settling frames seen since the first frame start
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= '0;
        end else if (w_skip_clear) begin
            r_skip_cnt <= '0;
        end else if (w_skip_inc) begin
            r_skip_cnt <= r_skip_cnt + SKW'(1);
        end
    end

    // Byte pairing: phase restarts whenever href drops, so odd bytes vanish
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_high  <= 8'h00;
        end else begin
            r_phase <= w_capture ? ~r_phase : 1'b0;
            if (w_capture && !r_phase) begin
                r_high <= r_data;
            end
        end
    end

    // Write pointer and BRAM write port; writes at or past the end are blocked
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= 17'd0;
            r_frame_addr  <= 17'd0;
            r_frame_pixel <= 16'h0000;
            r_frame_we    <= 1'b0;
        end else begin
            r_frame_we <= 1'b0;
            if (w_ptr_clear) begin
                r_wr_ptr <= 17'd0;
            end else if (w_issue && w_in_range) begin
                r_frame_addr  <= r_wr_ptr;
                r_frame_pixel <= {r_high, r_data};
                r_frame_we    <= 1'b1;
                r_wr_ptr      <= r_wr_ptr + 17'd1;
            end
        end
    end

    // Frame-end pulse and per-frame sticky overflow
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            if (w_vsync_fall) begin
                r_overflow <= 1'b0;
            end else if (w_issue && !w_in_range) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign frame_addr  = r_frame_addr;
    assign frame_pixel = r_frame_pixel;
    assign frame_we    = r_frame_we;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;

endmodule
